// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: moves bytes from the transmit FIFO head into the UART transmitter one frame
// at a time. It can insert an idle gap after each frame, drain the FIFO without sending, and
// count the frames that have been sent.
module uart_tx_scheduler #(
  parameter int unsigned DBIT  = 8,
  parameter int unsigned GAP_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             flush,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             fifo_empty,
  input  logic [DBIT-1:0]  fifo_rd_data,
  output logic             fifo_rd,
  input  logic             tx_ready,
  input  logic             tx_done_tick,
  output logic             tx_start,
  output logic [DBIT-1:0]  tx_data,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StGap,
    StFlush
  } state_e;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [DBIT-1:0]  data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q;
  logic             pop;

  // Next-state, datapath loads and the FIFO pop decode.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Flush wins over a normal send.
        if (flush && !fifo_empty) begin
          state_d = StFlush;
        end else if (en && !fifo_empty && tx_ready) begin
          data_d  = fifo_rd_data;
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (tx_done_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (gap_cycles == '0) begin
            state_d = StIdle;
          end else begin
            // The gap length is captured once here; later changes do not affect it.
            gap_d   = gap_cycles - GAP_W'(1);
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      StFlush: begin
        if (fifo_empty || !flush) begin
          state_d = StIdle;
        end else begin
          pop = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      start_q <= (state_d == StStart);
    end
  end

  // The pop decode would fire from IDLE during reset, so hold it off until reset is released.
  assign fifo_rd   = pop & reset_n;
  assign busy      = (state_q != StIdle);
  assign tx_start  = start_q;
  assign tx_data   = data_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler. It contains a FIFO model and a transmitter model. Each
// queued byte pushes an expected start event. The negedge monitor pops an expected event on
// every tx_start and checks the data and the spacing between starts.
module tb_uart_tx_scheduler;
  localparam int unsigned DBIT  = 8;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned CNT_W = 16;

  logic             clk          = 1'b0;
  logic             reset_n      = 1'b0;
  logic             en           = 1'b0;
  logic             flush        = 1'b0;
  logic [GAP_W-1:0] gap_cycles   = '0;
  logic             fifo_empty   = 1'b1;
  logic [DBIT-1:0]  fifo_rd_data = '0;
  logic             tx_ready     = 1'b1;
  logic             tx_done_tick = 1'b0;
  wire              fifo_rd, tx_start, busy;
  wire  [DBIT-1:0]  tx_data;
  wire  [CNT_W-1:0] frame_cnt;
  // A narrow-counter copy shares all inputs and is used only for the counter wrap check.
  wire              s_fifo_rd, s_tx_start, s_busy;
  wire  [DBIT-1:0]  s_tx_data;
  wire  [3:0]       s_frame_cnt;

  uart_tx_scheduler #(.DBIT(DBIT), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .gap_cycles(gap_cycles),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd(fifo_rd),
    .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .frame_cnt(frame_cnt)
  );

  uart_tx_scheduler #(.DBIT(DBIT), .GAP_W(GAP_W), .CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .gap_cycles(gap_cycles),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd(s_fifo_rd),
    .tx_ready(tx_ready), .tx_done_tick(tx_done_tick), .tx_start(s_tx_start),
    .tx_data(s_tx_data), .busy(s_busy), .frame_cnt(s_frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         spacing;  // required clocks since previous tx_start, 0 = don't care
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rd_cnt = 0;
  int         start_cnt = 0;
  int         last_rd_cyc = -10;
  int         last_start_cyc = -100;
  bit         rd_seen = 1'b0;
  bit         model_on = 1'b1;
  int         frame_len = 10;
  int         tx_cnt = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b, input bit has_exp, input int sp);
    exp_t e;
    fifo_q.push_back(b);
    if (has_exp) begin
      e.data    = b;
      e.spacing = sp;
      exp_q.push_back(e);
    end
    upd_fifo();
  endtask

  // Advance one clock: apply the pop seen last cycle, then step the transmitter model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) fifo_q.delete(0);
    tx_done_tick = 1'b0;
    if (model_on) begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done_tick = 1'b1;
          tx_ready     = 1'b1;
        end
      end
      if (tx_start) begin
        tx_cnt   = frame_len;
        tx_ready = 1'b0;
      end
    end else begin
      tx_cnt = 0;
    end
    upd_fifo();
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int i = 0;
    while (frame_cnt != CNT_W'(target) && i < budget) begin
      tick();
      i++;
    end
    chk(name, frame_cnt, target);
  endtask

  task automatic wait_start(input int target, input int budget, input string name);
    int i = 0;
    while (start_cnt != target && i < budget) begin
      tick();
      i++;
    end
    chk(name, start_cnt, target);
  endtask

  // Monitor: samples on the falling edge and checks each tx_start against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      rd_seen = fifo_rd;
      if (fifo_rd) begin
        chk("rd_when_empty", fifo_empty, 0);
        rd_cnt++;
        last_rd_cyc = cyc;
      end
      if (tx_start) begin
        start_cnt++;
        chk("start_after_rd", cyc - last_rd_cyc, 1);
        chk("busy_at_start", busy, 1);
        chk("start_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e.data);
          if (e.spacing != 0) chk("start_spacing", cyc - last_start_cyc, e.spacing);
        end
        last_start_cyc = cyc;
      end
    end
  end

  initial begin
    int rd0;
    int st0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    reset_n = 1'b1;
    tick();

    // Basic send.
    push(8'hA5, 1, 0);
    en = 1'b1;
    wait_frames(1, 100, "basic_frame_cnt");
    tick();
    chk("basic_busy", busy, 0);
    chk("basic_tx_data_held", tx_data, 8'hA5);
    chk("basic_rd_cnt", rd_cnt, 1);

    // Gap of 5 with 10-cycle frames: starts 10+5+2 = 17 clocks apart.
    gap_cycles = 8'd5;
    push(8'h11, 1, 0);
    push(8'h22, 1, 17);
    push(8'h33, 1, 17);
    wait_frames(4, 200, "gap_frame_cnt");
    repeat (10) tick();
    chk("gap_busy", busy, 0);
    gap_cycles = 8'd0;

    // Flush: four pops, no starts, counter unchanged.
    rd0   = rd_cnt;
    st0   = start_cnt;
    flush = 1'b1;
    push(8'h01, 0, 0);
    push(8'h02, 0, 0);
    push(8'h03, 0, 0);
    push(8'h04, 0, 0);
    repeat (10) tick();
    chk("flush_pops", rd_cnt - rd0, 4);
    chk("flush_no_start", start_cnt - st0, 0);
    chk("flush_frame_cnt", frame_cnt, 4);
    chk("flush_busy", busy, 0);
    chk("flush_fifo_left", fifo_q.size(), 0);
    flush = 1'b0;
    tick();

    // Enable drop during WAIT: the frame finishes, then no further pops.
    rd0 = rd_cnt;
    st0 = start_cnt;
    push(8'h5A, 1, 0);
    push(8'hC3, 0, 0);
    wait_start(st0 + 1, 50, "endrop_start");
    repeat (3) tick();
    en = 1'b0;
    wait_frames(5, 100, "endrop_frame_cnt");
    repeat (20) tick();
    chk("endrop_pops", rd_cnt - rd0, 1);
    chk("endrop_busy", busy, 0);
    begin
      exp_t e;
      e.data    = 8'hC3;
      e.spacing = 0;
      exp_q.push_back(e);
    end
    en = 1'b1;
    wait_frames(6, 100, "endrop_resume");
    tick();

    // tx_ready low: no pop even with data queued.
    model_on = 1'b0;
    tx_ready = 1'b0;
    rd0      = rd_cnt;
    st0      = start_cnt;
    push(8'h77, 1, 0);
    repeat (8) tick();
    chk("notready_pops", rd_cnt - rd0, 0);
    chk("notready_busy", busy, 0);

    // Reset during WAIT, with another byte waiting to be popped.
    tx_ready = 1'b1;
    wait_start(st0 + 1, 20, "rstmid_start");
    repeat (2) tick();
    push(8'h99, 0, 0);
    chk("rstmid_busy_before", busy, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_tx_start", tx_start, 0);
    chk("rstmid_fifo_rd", fifo_rd, 0);
    chk("rstmid_tx_data", tx_data, 0);
    chk("rstmid_frame_cnt", frame_cnt, 0);
    en = 1'b0;
    fifo_q.delete();
    upd_fifo();
    repeat (2) tick();
    reset_n = 1'b1;
    st0     = start_cnt;
    tick();
    tx_done_tick = 1'b1;
    repeat (3) tick();
    chk("stray_done_frame_cnt", frame_cnt, 0);
    chk("stray_done_busy", busy, 0);
    chk("stray_done_no_start", start_cnt - st0, 0);

    // 16 short frames: the 4-bit copy wraps to 0.
    model_on  = 1'b1;
    frame_len = 2;
    en        = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i + 8'h40), 1, 0);
    wait_frames(16, 1000, "wrap_frame_cnt");
    chk("wrap_small_cnt", s_frame_cnt, 0);
    tick();

    // Empty FIFO with en high: never pops.
    rd0 = rd_cnt;
    repeat (10) tick();
    chk("empty_no_pop", rd_cnt - rd0, 0);
    chk("exp_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
